// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external combinational ALU between two requesters
module alu_share_arbiter #(
  parameter int CNT_W   = 16,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req_instr_0,
  input  logic [31:0]      req_instr_1,
  input  logic [31:0]      req_a_0,
  input  logic [31:0]      req_a_1,
  input  logic [31:0]      req_b_0,
  input  logic [31:0]      req_b_1,
  output logic [31:0]      alu_instruction,
  output logic [31:0]      alu_regA,
  output logic [31:0]      alu_regB,
  input  logic [31:0]      alu_result,
  input  logic [2:0]       alu_flags,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_result_0,
  output logic [31:0]      rsp_result_1,
  output logic [2:0]       rsp_flags_0,
  output logic [2:0]       rsp_flags_1,
  output logic [CNT_W-1:0] op_count
);
  logic [1:0] eligible;
  logic [1:0] grant;
  logic       prio;
  // a full buffer that is draining this cycle can accept the next result
  assign eligible = req_valid & (~rsp_valid | rsp_ready);
  assign grant[0] = ~reset & eligible[0] & (~eligible[1] | ~prio);
  assign grant[1] = ~reset & eligible[1] & (~eligible[0] | prio);
  assign req_ready = grant;
  assign alu_instruction = grant[0] ? req_instr_0 : grant[1] ? req_instr_1 : '0;
  assign alu_regA        = grant[0] ? req_a_0     : grant[1] ? req_a_1     : '0;
  assign alu_regB        = grant[0] ? req_b_0     : grant[1] ? req_b_1     : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid    <= '0;
      rsp_result_0 <= '0;
      rsp_result_1 <= '0;
      rsp_flags_0  <= '0;
      rsp_flags_1  <= '0;
      op_count     <= '0;
      prio         <= RR_INIT;
    end else begin
      rsp_valid <= grant | (rsp_valid & ~rsp_ready);
      op_count  <= op_count + {{(CNT_W-1){1'b0}}, |grant};
      if (grant[0]) begin
        rsp_result_0 <= alu_result;
        rsp_flags_0  <= alu_flags;
        prio         <= 1'b1;
      end
      if (grant[1]) begin
        rsp_result_1 <= alu_result;
        rsp_flags_1  <= alu_flags;
        prio         <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of arbitration, buffering, counter wrap and reset
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_instr_0, req_instr_1, req_a_0, req_a_1, req_b_0, req_b_1;
  logic [31:0] alu_instruction, alu_regA, alu_regB, alu_result;
  logic [2:0]  alu_flags;
  logic [31:0] rsp_result_0, rsp_result_1;
  logic [2:0]  rsp_flags_0, rsp_flags_1;
  logic [15:0] op_count;
  logic [1:0]  w_req_ready, w_rsp_valid;
  logic [31:0] w_instr, w_a, w_b, w_res0, w_res1;
  logic [2:0]  w_fl0, w_fl1;
  logic [3:0]  w_count;
  logic [31:0] zero32 = '0;
  logic [2:0]  zero3 = '0;
  logic [31:0] op2;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  alu_share_arbiter u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_instr_0(req_instr_0), .req_instr_1(req_instr_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1), .req_b_0(req_b_0), .req_b_1(req_b_1),
    .alu_instruction(alu_instruction), .alu_regA(alu_regA), .alu_regB(alu_regB),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result_0(rsp_result_0), .rsp_result_1(rsp_result_1),
    .rsp_flags_0(rsp_flags_0), .rsp_flags_1(rsp_flags_1), .op_count(op_count)
  );

  alu_share_arbiter #(.CNT_W(4)) u_wrap (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(w_req_ready),
    .req_instr_0(req_instr_0), .req_instr_1(req_instr_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1), .req_b_0(req_b_0), .req_b_1(req_b_1),
    .alu_instruction(w_instr), .alu_regA(w_a), .alu_regB(w_b),
    .alu_result(zero32), .alu_flags(zero3),
    .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result_0(w_res0), .rsp_result_1(w_res1),
    .rsp_flags_0(w_fl0), .rsp_flags_1(w_fl1), .op_count(w_count)
  );

  // toy ALU: opcode 0 adds regs, otherwise adds sign-extended imm; flags = {ovf, neg, zero}
  always_comb begin
    op2 = (alu_instruction[31:26] == 6'd0) ? alu_regB : {{16{alu_instruction[15]}}, alu_instruction[15:0]};
    alu_result = alu_regA + op2;
    alu_flags = {(alu_regA[31] == op2[31]) && (alu_result[31] != alu_regA[31]), alu_result[31], alu_result == 32'd0};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
    req_instr_0 = 32'h00010021; req_a_0 = 32'd1; req_b_0 = 32'hFFFFFFFE;
    req_instr_1 = 32'h00000021; req_a_1 = 32'd5; req_b_1 = 32'd7;
    cyc();
    #1 chk("rst_req_ready", req_ready, 2'b00);
    cyc();
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_op_count", op_count, 0);
    chk("rst_rsp_result_0", rsp_result_0, 0);
    chk("rst_rsp_flags_1", rsp_flags_1, 0);
    // single op on requester 0
    reset = 1'b0; req_valid = 2'b01; rsp_ready = 2'b01;
    #1 chk("t1_req_ready", req_ready, 2'b01);
    chk("t1_alu_instr", alu_instruction, 32'h00010021);
    chk("t1_alu_regB", alu_regB, 32'hFFFFFFFE);
    cyc();
    req_valid = 2'b00;
    #1 chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_result", rsp_result_0, 32'hFFFFFFFF);
    chk("t1_flags", rsp_flags_0, 3'b010);
    chk("t1_op_count", op_count, 1);
    chk("t1_idle_alu", alu_instruction, 0);
    cyc();
    chk("t1_drained", rsp_valid, 2'b00);
    // contention alternates starting from requester 0
    do_reset();
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("t2_grant%0d", k), req_ready, (k % 2) ? 2'b10 : 2'b01);
      cyc();
    end
    req_valid = 2'b00;
    #1 chk("t2_op_count", op_count, 6);
    chk("t2_rsp_valid", rsp_valid, 2'b10);
    chk("t2_result_1", rsp_result_1, 32'd12);
    cyc();
    // backpressure on requester 0 never blocks requester 1
    req_valid = 2'b11; rsp_ready = 2'b10; req_a_0 = 32'd10; req_b_0 = 32'd20; req_instr_0 = 32'h00000021;
    #1 chk("t3_first_grant", req_ready, 2'b01);
    cyc();
    req_a_0 = 32'd100; req_b_0 = 32'd1;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("t3_blocked%0d", k), req_ready, 2'b10);
      chk($sformatf("t3_held%0d", k), rsp_result_0, 32'd30);
      cyc();
    end
    rsp_ready = 2'b11;
    #1 chk("t3_release", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    #1 chk("t3_rsp_valid0", rsp_valid[0], 1'b1);
    chk("t3_replaced", rsp_result_0, 32'd101);
    chk("t3_op_count", op_count, 11);
    cyc();
    // addiu with signed overflow held under backpressure
    req_valid = 2'b10; rsp_ready = 2'b00;
    req_instr_1 = 32'h24017FFF; req_a_1 = 32'h7FFFFFFF; req_b_1 = 32'd1;
    #1 chk("t4_alu_instr", alu_instruction, 32'h24017FFF);
    chk("t4_alu_regA", alu_regA, 32'h7FFFFFFF);
    cyc();
    req_valid = 2'b00;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("t4_result%0d", k), rsp_result_1, 32'h80007FFE);
      chk($sformatf("t4_flags%0d", k), rsp_flags_1, 3'b110);
      chk($sformatf("t4_valid%0d", k), rsp_valid[1], 1'b1);
      cyc();
    end
    chk("t4_op_count", op_count, 12);
    rsp_ready = 2'b11;
    cyc();
    // 17 grants wrap a 4-bit counter to 1
    do_reset();
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 17; k++) cyc();
    chk("t5_wrap", w_count, 4'd1);
    chk("t5_count16", op_count, 17);
    // reset with both buffers full
    rsp_ready = 2'b00;
    cyc();
    cyc();
    chk("t6_full", rsp_valid, 2'b11);
    reset = 1'b1;
    #1 chk("t6_no_grant", req_ready, 2'b00);
    cyc();
    reset = 1'b0; rsp_ready = 2'b11;
    #1 chk("t6_rsp_valid", rsp_valid, 2'b00);
    chk("t6_op_count", op_count, 0);
    chk("t6_wrap_count", w_count, 0);
    chk("t6_first_grant", req_ready, 2'b01);
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
